// File: rtl/dec_add_round_key.sv
// -----------------------------------------------------------------------------
// dec_add_round_key
//
// Registered AddRoundKey stage of the AES-128 decryption datapath. It sits
// directly upstream of the inverse mix-column stage. A local key store holds the
// expanded round keys. Each accepted 128-bit state is XORed with the key chosen
// by its round number. The result and the round number (count_out) go to the
// inverse mix-column stage, which passes data through unmixed on round 0.
// The output is a one-entry register with valid/ready handshakes on both sides.
//
// Configuration macro:
//   ARK_RANGE_CHECK_EN - defined  : round_in > 10 uses an all-zero key, and the
//                                   sticky range_err flag is set.
//                        undefined: round_in > 10 clamps to the last key, and
//                                   range_err is tied to 0.
//
// Ports:
//   clk          rising-edge clock
//   n_rst        asynchronous active-low reset
//   key_wr_en    key store write strobe
//   key_wr_addr  round index of the key being written (values > 10 are ignored)
//   key_wr_data  round key value
//   keys_ready   all entries written since reset (sticky)
//   in_valid     upstream state valid
//   in_ready     stage can accept a state this cycle
//   data_in      state from the inverse sub-bytes stage
//   round_in     round number of data_in
//   out_valid    data_out/count_out valid
//   out_ready    downstream accepts output
//   data_out     state XOR round key
//   count_out    registered round number, feeds the inverse mix-column stage
//   range_err    sticky: a block arrived with round_in > 10
// -----------------------------------------------------------------------------
module dec_add_round_key #(
  parameter int unsigned NUM_KEYS = 11
) (
  input  logic         clk,
  input  logic         n_rst,
  input  logic         key_wr_en,
  input  logic [3:0]   key_wr_addr,
  input  logic [127:0] key_wr_data,
  output logic         keys_ready,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] data_in,
  input  logic [3:0]   round_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] data_out,
  output logic [3:0]   count_out,
  output logic         range_err
);

  localparam int unsigned LastKey = NUM_KEYS - 1;

  // Key store and written mask
  logic [127:0]        key_q [NUM_KEYS];
  logic [NUM_KEYS-1:0] key_we;
  logic [NUM_KEYS-1:0] mask_q, mask_d;
  logic                keys_ready_q;

  // Output register
  logic         out_valid_q, out_valid_d;
  logic [127:0] data_q, data_d;
  logic [3:0]   count_q, count_d;

  logic         accept;
  logic         drain;
  logic         in_range;
  logic [127:0] key_sel;

  // ---------------------------------------------------------------------------
  // Key store write decode
  // ---------------------------------------------------------------------------
  always_comb begin
    key_we = '0;
    mask_d = mask_q;
    for (int unsigned i = 0; i < NUM_KEYS; i++) begin
      if (key_wr_en && ({28'd0, key_wr_addr} == i)) begin
        key_we[i] = 1'b1;
        mask_d[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int unsigned i = 0; i < NUM_KEYS; i++) begin
        key_q[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < NUM_KEYS; i++) begin
        if (key_we[i]) begin
          key_q[i] <= key_wr_data;
        end
      end
    end
  end

  // The mask only ever gains bits, so keys_ready stays high once it has risen.
  // Using mask_d makes keys_ready rise right after the edge that fills the
  // last entry.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      mask_q       <= '0;
      keys_ready_q <= 1'b0;
    end else begin
      mask_q       <= mask_d;
      keys_ready_q <= &mask_d;
    end
  end

  assign keys_ready = keys_ready_q;

  // ---------------------------------------------------------------------------
  // Key selection
  // key_q is read before this cycle's write lands, so a same-cycle write to the
  // selected entry is seen only by later accepts.
  // ---------------------------------------------------------------------------
  assign in_range = ({28'd0, round_in} < NUM_KEYS);

  always_comb begin
    key_sel = '0;
    for (int unsigned i = 0; i < NUM_KEYS; i++) begin
      if ({28'd0, round_in} == i) begin
        key_sel = key_q[i];
      end
    end
`ifndef ARK_RANGE_CHECK_EN
    // An out-of-range round clamps to the final round key.
    if (!in_range) begin
      key_sel = key_q[LastKey];
    end
`endif
    // With the range check on, an out-of-range round matches no entry, so the
    // key stays zero and the data passes through unmodified.
  end

  // ---------------------------------------------------------------------------
  // Handshake and output register
  // ---------------------------------------------------------------------------
  assign in_ready = keys_ready_q & (~out_valid_q | out_ready);
  assign accept   = in_valid & in_ready;
  assign drain    = out_valid_q & out_ready;

  always_comb begin
    out_valid_d = out_valid_q;
    data_d      = data_q;
    count_d     = count_q;
    if (accept) begin
      out_valid_d = 1'b1;
      data_d      = data_in ^ key_sel;
      count_d     = round_in;
    end else if (drain) begin
      // data_out and count_out keep their last values
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      out_valid_q <= 1'b0;
      data_q      <= '0;
      count_q     <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      data_q      <= data_d;
      count_q     <= count_d;
    end
  end

  assign out_valid = out_valid_q;
  assign data_out  = data_q;
  assign count_out = count_q;

  // ---------------------------------------------------------------------------
  // Range error flag
  // ---------------------------------------------------------------------------
`ifdef ARK_RANGE_CHECK_EN
  logic range_err_q;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      range_err_q <= 1'b0;
    end else if (accept && !in_range) begin
      range_err_q <= 1'b1;
    end
  end

  assign range_err = range_err_q;
`else
  assign range_err = 1'b0;
`endif

endmodule

// File: tb/tb_dec_add_round_key.sv
module tb_dec_add_round_key;

  logic         clk = 1'b0;
  logic         n_rst;
  logic         key_wr_en;
  logic [3:0]   key_wr_addr;
  logic [127:0] key_wr_data;
  logic         keys_ready;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] data_in;
  logic [3:0]   round_in;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] data_out;
  logic [3:0]   count_out;
  logic         range_err;

  dec_add_round_key #(.NUM_KEYS(11)) dut (
    .clk         (clk),
    .n_rst       (n_rst),
    .key_wr_en   (key_wr_en),
    .key_wr_addr (key_wr_addr),
    .key_wr_data (key_wr_data),
    .keys_ready  (keys_ready),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .data_in     (data_in),
    .round_in    (round_in),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .data_out    (data_out),
    .count_out   (count_out),
    .range_err   (range_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [127:0] km [11];
  logic         ev;
  logic [127:0] ed;
  logic [3:0]   ec;
  logic         erange;

`ifdef ARK_RANGE_CHECK_EN
  localparam bit RangeChk = 1'b1;
`else
  localparam bit RangeChk = 1'b0;
`endif

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // AddRoundKey rule: in-range rounds use their key; out-of-range rounds either
  // pass through (range check) or use the last key.
  function automatic logic [127:0] ref_ark(input logic [127:0] d, input logic [3:0] r);
    if (r <= 4'd10) return d ^ km[r];
    if (RangeChk) return d;
    return d ^ km[10];
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_key(input logic [3:0] a, input logic [127:0] d);
    key_wr_en   = 1'b1;
    key_wr_addr = a;
    key_wr_data = d;
    step();
    key_wr_en = 1'b0;
    if (a <= 4'd10) km[a] = d;
  endtask

  task automatic load_keys();
    logic [3:0] nib;
    for (int i = 0; i < 11; i++) begin
      chk("keys_ready_pre", {127'd0, keys_ready}, 128'd0);
      chk("in_ready_pre", {127'd0, in_ready}, 128'd0);
      nib = 4'(i);
      wr_key(4'(i), {32{nib}});
    end
    chk("keys_ready_post", {127'd0, keys_ready}, 128'd1);
  endtask

  initial begin
    logic [127:0] a_dat, b_dat, old_k3, new_k3, d;
    logic         m_ready, acc;

    n_rst = 1'b0; key_wr_en = 1'b0; key_wr_addr = '0; key_wr_data = '0;
    in_valid = 1'b0; data_in = '0; round_in = '0; out_ready = 1'b0;
    for (int i = 0; i < 11; i++) km[i] = '0;
    erange = 1'b0;
    #3;
    chk("rst_data_out", data_out, 128'd0);
    chk("rst_count_out", {124'd0, count_out}, 128'd0);
    chk("rst_out_valid", {127'd0, out_valid}, 128'd0);
    chk("rst_keys_ready", {127'd0, keys_ready}, 128'd0);
    chk("rst_range_err", {127'd0, range_err}, 128'd0);
    chk("rst_in_ready", {127'd0, in_ready}, 128'd0);
    @(posedge clk); #1;
    n_rst = 1'b1;

    // An ignored out-of-range address must not complete the mask.
    wr_key(4'd11, rnd128());
    load_keys();

    // First block: zero state at round 10 yields k[10].
    data_in = '0; round_in = 4'd10; in_valid = 1'b1; out_ready = 1'b1;
    #1;
    chk("in_ready_loaded", {127'd0, in_ready}, 128'd1);
    step();
    chk("first_data", data_out, {32{4'ha}});
    chk("first_count", {124'd0, count_out}, 128'd10);
    chk("first_valid", {127'd0, out_valid}, 128'd1);
    in_valid = 1'b0;
    step();
    chk("drain_valid", {127'd0, out_valid}, 128'd0);
    chk("drain_hold", data_out, {32{4'ha}});

    // Back-to-back stream of rounds 10..0.
    for (int r = 10; r >= 0; r--) begin
      d = rnd128();
      data_in = d; round_in = 4'(r); in_valid = 1'b1; out_ready = 1'b1;
      step();
      chk("stream_valid", {127'd0, out_valid}, 128'd1);
      chk("stream_data", data_out, ref_ark(d, 4'(r)));
      chk("stream_count", {124'd0, count_out}, 128'(r));
    end
    in_valid = 1'b0;
    step();
    chk("stream_end_valid", {127'd0, out_valid}, 128'd0);
    chk("stream_end_count", {124'd0, count_out}, 128'd0);

    // Backpressure: output held while downstream stalls.
    a_dat = rnd128(); b_dat = rnd128();
    data_in = a_dat; round_in = 4'd5; in_valid = 1'b1; out_ready = 1'b0;
    step();
    data_in = b_dat; round_in = 4'd7;
    for (int i = 0; i < 5; i++) begin
      chk("bp_in_ready", {127'd0, in_ready}, 128'd0);
      chk("bp_valid", {127'd0, out_valid}, 128'd1);
      chk("bp_data", data_out, ref_ark(a_dat, 4'd5));
      chk("bp_count", {124'd0, count_out}, 128'd5);
      step();
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_ready", {127'd0, in_ready}, 128'd1);
    step();
    chk("bp_next_data", data_out, ref_ark(b_dat, 4'd7));
    chk("bp_next_count", {124'd0, count_out}, 128'd7);
    in_valid = 1'b0;
    step();
    chk("bp_drain", {127'd0, out_valid}, 128'd0);

    // Key write colliding with an accept on the same index.
    old_k3 = km[3]; new_k3 = rnd128(); a_dat = rnd128(); b_dat = rnd128();
    data_in = a_dat; round_in = 4'd3; in_valid = 1'b1;
    key_wr_en = 1'b1; key_wr_addr = 4'd3; key_wr_data = new_k3;
    step();
    key_wr_en = 1'b0; km[3] = new_k3;
    chk("collide_old_key", data_out, a_dat ^ old_k3);
    data_in = b_dat;
    step();
    chk("collide_new_key", data_out, b_dat ^ new_k3);

    // Out-of-range round.
    a_dat = rnd128();
    data_in = a_dat; round_in = 4'd12;
    step();
    chk("range_data", data_out, RangeChk ? a_dat : (a_dat ^ km[10]));
    chk("range_count", {124'd0, count_out}, 128'd12);
    chk("range_err", {127'd0, range_err}, {127'd0, RangeChk});
    data_in = rnd128(); round_in = 4'd2;
    step();
    chk("range_err_sticky", {127'd0, range_err}, {127'd0, RangeChk});
    in_valid = 1'b0;
    step();
    erange = RangeChk;
    ev = 1'b0; ed = data_out; ec = 4'd2;

    // Randomized traffic against the reference model.
    for (int n = 0; n < 300; n++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      round_in  = ($urandom_range(0, 15) == 0) ? 4'($urandom_range(11, 15))
                                               : 4'($urandom_range(0, 10));
      data_in   = rnd128();
      key_wr_en = ($urandom_range(0, 7) == 0);
      key_wr_addr = 4'($urandom_range(0, 15));
      key_wr_data = rnd128();
      #1;
      m_ready = !ev || out_ready;
      chk("rnd_in_ready", {127'd0, in_ready}, {127'd0, m_ready});
      step();
      acc = in_valid && m_ready;
      if (acc) begin
        ev = 1'b1;
        ed = ref_ark(data_in, round_in);
        ec = round_in;
        if (round_in > 4'd10 && RangeChk) erange = 1'b1;
      end else if (ev && out_ready) begin
        ev = 1'b0;
      end
      if (key_wr_en && key_wr_addr <= 4'd10) km[key_wr_addr] = key_wr_data;
      chk("rnd_valid", {127'd0, out_valid}, {127'd0, ev});
      chk("rnd_data", data_out, ed);
      chk("rnd_count", {124'd0, count_out}, {124'd0, ec});
      chk("rnd_range_err", {127'd0, range_err}, {127'd0, erange});
    end
    key_wr_en = 1'b0;

    // Reset in the middle of operation.
    data_in = rnd128(); round_in = 4'd1; in_valid = 1'b1; out_ready = 1'b0;
    step();
    #2;
    n_rst = 1'b0;
    #1;
    chk("mid_rst_valid", {127'd0, out_valid}, 128'd0);
    chk("mid_rst_data", data_out, 128'd0);
    chk("mid_rst_keys_ready", {127'd0, keys_ready}, 128'd0);
    chk("mid_rst_in_ready", {127'd0, in_ready}, 128'd0);
    chk("mid_rst_range_err", {127'd0, range_err}, 128'd0);
    step();
    n_rst = 1'b1;
    for (int i = 0; i < 11; i++) km[i] = '0;
    wr_key(4'd0, rnd128());
    chk("mid_rst_partial", {127'd0, keys_ready}, 128'd0);
    chk("mid_rst_no_accept", {127'd0, out_valid}, 128'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
